forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/fwd_pkg.sv | 33 +++
 rtl/fwd_match.sv | 26 ++
 rtl/forward_hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared definitions for the forwarding / hazard unit:
//               operand-select encodings, stage-entry field widths and the
//               stage-entry record carried through EX, MEM and WB.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

  // Field widths
  localparam int REG_W = 5;   // register specifier width
  localparam int SEL_W = 2;   // operand-select width
  localparam int CNT_W = 16;  // stall counter width

  // Operand-select encodings (3 is reserved and never produced)
  localparam logic [SEL_W-1:0] FWD_REG   = 2'd0;  // register / pipeline value
  localparam logic [SEL_W-1:0] FWD_EXMEM = 2'd1;  // EX/MEM ALU result
  localparam logic [SEL_W-1:0] FWD_MEMWB = 2'd2;  // MEM/WB writeback result

  // One pipeline-stage entry as tracked by the hazard unit
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             regwr;
    logic             memrd;
    logic             memwr;
    logic [REG_W-1:0] rt;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_match
// Description : Producer/consumer register match. A stage entry matches a
//               register only if it writes the register file, targets a
//               non-zero register, and targets exactly that register.
//               Register 0 is hard-wired and never matches.
// Ports       : entry_dest  in  5  destination of the stage entry
//               entry_regwr in  1  stage entry writes the register file
//               reg_in      in  5  register being read by the consumer
//               match       out 1  forwarding / hazard match
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
  import fwd_pkg::*;
(
  input  logic [REG_W-1:0] entry_dest,
  input  logic             entry_regwr,
  input  logic [REG_W-1:0] reg_in,
  output logic             match
);

  assign match = entry_regwr && (entry_dest != '0) && (entry_dest == reg_in);

endmodule : fwd_match
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit
// Description : Forwarding and load-use hazard unit for a 5-stage pipeline.
//               Tracks EX, MEM and WB stage entries, raises a combinational
//               Stall on load-use hazards, and registers operand-select
//               codes one cycle ahead of the instruction that uses them.
// Ports       : clk, rst            clock, async active-high reset
//               id_rs/id_rt         source registers of the ID instruction
//               id_use_rs/id_use_rt ID instruction actually reads rs / rt
//               id_dest, id_regwr   ID destination and write enable
//               id_memrd, id_memwr  ID instruction is a load / store
//               Flush               discard the ID instruction
//               Stall               load-use hazard (combinational)
//               ForwardA/B          EX operand selects (registered)
//               ForwardC            MEM store-data select (registered)
//               stall_cnt           saturating count of stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module forward_hazard_unit
  import fwd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwr,
  input  logic             id_memrd,
  input  logic             id_memwr,
  input  logic             Flush,
  output logic             Stall,
  output logic [SEL_W-1:0] ForwardA,
  output logic [SEL_W-1:0] ForwardB,
  output logic [SEL_W-1:0] ForwardC,
  output logic [CNT_W-1:0] stall_cnt
);

  // Stage entries
  stage_t ex_q, ex_d;
  stage_t mem_q, mem_d;
  stage_t wb_q, wb_d;

  // Registered selects and counter
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0] fwd_b_q, fwd_b_d;
  logic [SEL_W-1:0] fwd_c_q, fwd_c_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Match results
  logic ex_hit_rs;
  logic ex_hit_rt;
  logic mem_hit_rs;
  logic mem_hit_rt;
  logic mem_hit_st;   // MEM entry produces the register the EX store writes out

  logic   stall;
  logic   bubble;
  stage_t id_entry;

  fwd_match u_match_ex_rs (
    .entry_dest  (ex_q.dest),
    .entry_regwr (ex_q.regwr),
    .reg_in      (id_rs),
    .match       (ex_hit_rs)
  );

  fwd_match u_match_ex_rt (
    .entry_dest  (ex_q.dest),
    .entry_regwr (ex_q.regwr),
    .reg_in      (id_rt),
    .match       (ex_hit_rt)
  );

  fwd_match u_match_mem_rs (
    .entry_dest  (mem_q.dest),
    .entry_regwr (mem_q.regwr),
    .reg_in      (id_rs),
    .match       (mem_hit_rs)
  );

  fwd_match u_match_mem_rt (
    .entry_dest  (mem_q.dest),
    .entry_regwr (mem_q.regwr),
    .reg_in      (id_rt),
    .match       (mem_hit_rt)
  );

  fwd_match u_match_mem_st (
    .entry_dest  (mem_q.dest),
    .entry_regwr (mem_q.regwr),
    .reg_in      (ex_q.rt),
    .match       (mem_hit_st)
  );

  always_comb begin
    // Flush wins over a load-use hazard: the consumer is being discarded.
    stall  = !Flush && ex_q.memrd &&
             ((ex_hit_rs && id_use_rs) || (ex_hit_rt && id_use_rt));
    bubble = stall || Flush;

    id_entry = '{dest:  id_dest,
                 regwr: id_regwr,
                 memrd: id_memrd,
                 memwr: id_memwr,
                 rt:    id_rt};

    ex_d  = bubble ? BUBBLE : id_entry;
    mem_d = ex_q;
    wb_d  = mem_q;

    // Selects are computed against the entries the ID instruction will
    // follow once it reaches EX: current EX becomes EX/MEM, current MEM
    // becomes MEM/WB. The younger producer (EX) has priority.
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (!bubble) begin
      if (ex_hit_rs)       fwd_a_d = FWD_EXMEM;
      else if (mem_hit_rs) fwd_a_d = FWD_MEMWB;

      if (ex_hit_rt)       fwd_b_d = FWD_EXMEM;
      else if (mem_hit_rt) fwd_b_d = FWD_MEMWB;
    end

    // Store in EX moves to MEM next cycle while its producer in MEM moves
    // to WB, so the store data must come from the writeback result.
    fwd_c_d = (ex_q.memwr && mem_hit_st) ? FWD_MEMWB : FWD_REG;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= BUBBLE;
      mem_q       <= BUBBLE;
      wb_q        <= BUBBLE;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      fwd_c_q     <= FWD_REG;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      fwd_c_q     <= fwd_c_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall     = stall;
  assign ForwardA  = fwd_a_q;
  assign ForwardB  = fwd_b_q;
  assign ForwardC  = fwd_c_q;
  assign stall_cnt = stall_cnt_q;

  // WB is tracked for pipeline completeness; it has no consumer here, and
  // the load/store flags and rt of MEM are not needed by any decision.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{wb_q, mem_q.memrd, mem_q.memwr, mem_q.rt};

endmodule : forward_hazard_unit
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_hazard_unit
// Description : Self-checking bench for forward_hazard_unit. Each step drives
//               one ID instruction, queues the expected Stall / selects /
//               counter, and the owning scenario task pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       regwr;
    logic       memrd;
    logic       memwr;
  } instr_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  fc;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_use_rs = 1'b0;
  logic        id_use_rt = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        id_regwr = 1'b0;
  logic        id_memrd = 1'b0;
  logic        id_memwr = 1'b0;
  logic        Flush = 1'b0;
  logic        Stall;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [1:0]  ForwardC;
  logic [15:0] stall_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  obs_t        exp_q[$];
  obs_t        got_q[$];

  forward_hazard_unit dut (
    .clk       (clk),
    .rst       (rst),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_dest   (id_dest),
    .id_regwr  (id_regwr),
    .id_memrd  (id_memrd),
    .id_memwr  (id_memwr),
    .Flush     (Flush),
    .Stall     (Stall),
    .ForwardA  (ForwardA),
    .ForwardB  (ForwardB),
    .ForwardC  (ForwardC),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction builders
  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = '0;
    i.rs = rs; i.rt = rt; i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.dest = rd; i.regwr = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input logic [4:0] rt, input logic [4:0] base);
    instr_t i = '0;
    i.rs = base; i.rt = rt; i.use_rs = 1'b1;
    i.dest = rt; i.regwr = 1'b1; i.memrd = 1'b1;
    return i;
  endfunction

  function automatic instr_t sw(input logic [4:0] rt, input logic [4:0] base);
    instr_t i = '0;
    i.rs = base; i.rt = rt; i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.memwr = 1'b1;
    return i;
  endfunction

  task automatic apply(input instr_t in, input logic fl);
    id_rs = in.rs; id_rt = in.rt; id_use_rs = in.use_rs; id_use_rt = in.use_rt;
    id_dest = in.dest; id_regwr = in.regwr; id_memrd = in.memrd; id_memwr = in.memwr;
    Flush = fl;
  endtask

  // Called at posedge+1. Drives one ID instruction, queues the expected
  // result, samples Stall mid-cycle and the registered outputs after the edge.
  task automatic step(input instr_t in, input logic fl, input logic e_stall,
                      input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] ec);
    obs_t e;
    obs_t g;
    apply(in, fl);
    if (e_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    e.stall = e_stall; e.fa = ea; e.fb = eb; e.fc = ec; e.cnt = exp_cnt;
    exp_q.push_back(e);
    #2;
    g.stall = Stall;
    @(posedge clk);
    #1;
    g.fa = ForwardA; g.fb = ForwardB; g.fc = ForwardC; g.cnt = stall_cnt;
    got_q.push_back(g);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({Stall, ForwardA, ForwardB, ForwardC, stall_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async got Stall=%0d A=%0d B=%0d C=%0d cnt=%0d want all 0",
               Stall, ForwardA, ForwardB, ForwardC, stall_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({Stall, ForwardA, ForwardB, ForwardC, stall_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL reset_held got Stall=%0d A=%0d B=%0d C=%0d cnt=%0d want all 0",
               Stall, ForwardA, ForwardB, ForwardC, stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    int n = 0;
    step(alu(3, 1, 2), 0, 0, 0, 0, 0);
    step(alu(4, 3, 5), 0, 0, 1, 0, 0);  // add $4,$3,$5 takes $3 from EX/MEM
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL back_to_back[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
  endtask

  task automatic test_memwb_fwd();
    obs_t e, g;
    int n = 0;
    step(alu(3, 1, 2), 0, 0, 0, 0, 0);
    step(nop(),        0, 0, 0, 0, 0);
    step(alu(6, 3, 3), 0, 0, 2, 2, 0);  // sub $6,$3,$3 takes $3 from MEM/WB
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL memwb_fwd[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
  endtask

  task automatic test_load_use();
    obs_t e, g;
    int n = 0;
    step(nop(),        0, 0, 0, 0, 0);
    step(lw(2, 0),     0, 0, 0, 0, 0);
    step(alu(7, 2, 1), 0, 1, 0, 0, 0);  // hazard: bubble enters EX
    step(alu(7, 2, 1), 0, 0, 2, 0, 0);  // replay: load now in MEM
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL load_use[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
    checks++;
    if (stall_cnt !== 16'd1) begin errors++;
      $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_zero_reg();
    obs_t e, g;
    int n = 0;
    step(alu(0, 1, 2), 0, 0, 0, 0, 0);
    step(alu(5, 0, 0), 0, 0, 0, 0, 0);
    step(lw(0, 0),     0, 0, 0, 0, 0);
    step(alu(5, 0, 0), 0, 0, 0, 0, 0);  // load to $0 must not stall
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL zero_reg[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
  endtask

  task automatic test_store_data();
    obs_t e, g;
    int n = 0;
    // Adjacent: add in WB while sw in MEM -> store data from writeback
    step(alu(3, 1, 2), 0, 0, 0, 0, 0);
    step(sw(3, 0),     0, 0, 0, 1, 0);
    step(nop(),        0, 0, 0, 0, 2);
    step(nop(),        0, 0, 0, 0, 0);
    // Extra gap: operand forwarded via ForwardB instead, store-data select stays 0
    step(alu(3, 1, 2), 0, 0, 0, 0, 0);
    step(nop(),        0, 0, 0, 0, 0);
    step(sw(3, 0),     0, 0, 0, 2, 0);
    step(nop(),        0, 0, 0, 0, 0);
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL store_data[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
  endtask

  task automatic test_flush();
    obs_t e, g;
    int n = 0;
    step(lw(2, 0),     0, 0, 0, 0, 0);
    step(alu(7, 2, 1), 1, 0, 0, 0, 0);  // flush beats the hazard
    step(alu(7, 2, 1), 0, 0, 2, 0, 0);  // EX holds a bubble, load in MEM
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL flush[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
  endtask

  task automatic test_reset_mid_stall();
    obs_t e, g;
    int n = 0;
    step(lw(2, 0), 0, 0, 0, 0, 0);
    apply(alu(7, 2, 1), 1'b0);
    #2;
    checks++;
    if (Stall !== 1'b1) begin errors++;
      $display("FAIL mid_stall_pre got Stall=%0d want 1", Stall); end
    rst = 1'b1;
    #1;
    checks++;
    if ({Stall, ForwardA, ForwardB, ForwardC, stall_cnt} !== 23'd0) begin errors++;
      $display("FAIL mid_stall_rst got Stall=%0d A=%0d B=%0d C=%0d cnt=%0d want all 0",
               Stall, ForwardA, ForwardB, ForwardC, stall_cnt); end
    exp_q.delete();
    got_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    step(alu(3, 1, 2), 0, 0, 0, 0, 0);  // first edge after reset captures ID
    step(alu(4, 3, 5), 0, 0, 1, 0, 0);
    step(nop(),        0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL post_reset[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
  endtask

  task automatic test_saturation();
    obs_t e, g;
    int n = 0;
    instr_t ld;
    ld = lw(2, 2);  // lw $2,0($2): every repeat depends on the previous load
    step(nop(), 0, 0, 0, 0, 0);
    // Stand in for 65530 earlier stalls, then produce 10 more.
    force dut.stall_cnt_q = 16'd65530;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 16'd65530;
    step(ld, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(ld, 0, 1, 0, 0, 0);
      step(ld, 0, 0, 2, 2, 0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n++; checks++;
      if (g !== e) begin errors++;
        $display("FAIL saturation[%0d] got S=%0d A=%0d B=%0d C=%0d cnt=%0d want S=%0d A=%0d B=%0d C=%0d cnt=%0d",
                 n, g.stall, g.fa, g.fb, g.fc, g.cnt, e.stall, e.fa, e.fb, e.fc, e.cnt); end
    end
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL saturation_final got %0d want 65535", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_memwb_fwd();
    test_load_use();
    test_zero_reg();
    test_store_data();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_forward_hazard_unit
`default_nettype wire
